// File: rtl/partial_sum_accumulator.sv
// Accumulates unsigned 35-bit partial products into a 50-bit running sum using an external adder.
// Define PSA_SATURATE_EN to clamp the accumulator to all ones on a carry out of bit 49.
module partial_sum_accumulator #(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [34:0] in_pp_i,
  input  logic        in_last_i,
  output logic [49:0] add_a_o,
  output logic [34:0] add_b_o,
  input  logic [50:0] add_sum_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [50:0] out_sum_o,
  output logic        out_ovf_o,
  output logic        out_trunc_o
);

  localparam logic [5:0] MaxCnt = 6'(MAX_BEATS);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e      state_q, state_d;
  logic [49:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic        trunc_q, trunc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        beat_acc;
  logic        at_limit;

  assign beat_acc = in_valid_i && in_ready_o;
  // True when the beat being accepted is the MAX_BEATS-th one.
  assign at_limit = (cnt_q + 6'd1) == MaxCnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (beat_acc) begin
          cnt_d   = cnt_q + 6'd1;
          ovf_d   = ovf_q | add_sum_i[50];
          acc_d   = add_sum_i[49:0];
`ifdef PSA_SATURATE_EN
          if (add_sum_i[50]) acc_d = '1;
`endif
          trunc_d = at_limit && !in_last_i;
          state_d = (in_last_i || at_limit) ? StDone : StAccum;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
          acc_d   = '0;
          ovf_d   = 1'b0;
          trunc_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q != StDone);
    out_valid_o = (state_q == StDone);
    add_a_o     = acc_q;
    add_b_o     = in_pp_i;
    out_sum_o   = {ovf_q, acc_q};
    out_ovf_o   = ovf_q;
    out_trunc_o = trunc_q;
  end

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Bench for partial_sum_accumulator: directed scenarios plus randomized traffic against a
// transaction-level model; the external adder is modelled here and can be overridden.
module tb_partial_sum_accumulator;

  localparam int unsigned MaxBeats = 4;
  localparam logic [49:0] AllOnes  = 50'h3FFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [34:0] in_pp;
  logic        in_last;
  logic [49:0] add_a;
  logic [34:0] add_b;
  logic [50:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [50:0] out_sum;
  logic        out_ovf;
  logic        out_trunc;
  logic        inj_en;
  logic [50:0] inj_val;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted beats of the current accumulation and the resulting value.
  logic [34:0] m_beats[$];
  logic [49:0] m_acc;
  logic        m_ovf;
  logic        m_trunc;
  logic        m_done;

  always #5 clk = ~clk;

  // External adder, optionally replaced by an injected sum.
  assign add_sum = inj_en ? inj_val : (51'(add_a) + 51'(add_b));

  partial_sum_accumulator #(.MAX_BEATS(MaxBeats)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pp_i     (in_pp),
    .in_last_i   (in_last),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_sum_i   (add_sum),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_ovf_o   (out_ovf),
    .out_trunc_o (out_trunc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_beats.delete();
    m_acc   = '0;
    m_ovf   = 1'b0;
    m_trunc = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(m_done));
    check_eq({tag, "_ready"}, 64'(in_ready), 64'(!m_done));
    check_eq({tag, "_sum"}, 64'(out_sum), 64'({m_ovf, m_acc}));
    check_eq({tag, "_ovf"}, 64'(out_ovf), 64'(m_ovf));
    check_eq({tag, "_trunc"}, 64'(out_trunc), 64'(m_trunc));
  endtask

  // Called on a falling edge; applies reset for one rising edge.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    inj_en   = 1'b0;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    check_outputs("reset");
    check_eq("reset_add_a", 64'(add_a), 64'd0);
  endtask

  // Called on a falling edge; drives one cycle, advances the model, checks on the next fall.
  task automatic cycle(input logic v, input logic [34:0] pp, input logic last, input logic ordy,
                       input logic inj, input logic [50:0] injv);
    logic [50:0] s;
    in_valid  = v;
    in_pp     = pp;
    in_last   = last;
    out_ready = ordy;
    inj_en    = inj;
    inj_val   = injv;
    #1;
    check_eq("add_b", 64'(add_b), 64'(pp));
    check_eq("add_a", 64'(add_a), 64'(m_acc));
    @(posedge clk);
    if (m_done) begin
      if (ordy) model_clear();
    end else if (v) begin
      s = inj ? injv : ({1'b0, m_acc} + {16'b0, pp});
      m_ovf = m_ovf | s[50];
`ifdef PSA_SATURATE_EN
      m_acc = s[50] ? AllOnes : s[49:0];
`else
      m_acc = s[49:0];
`endif
      m_beats.push_back(pp);
      if (last || m_beats.size() == MaxBeats) begin
        m_done  = 1'b1;
        m_trunc = !last;
      end
    end
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic beat(input logic [34:0] pp, input logic last);
    cycle(1'b1, pp, last, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [63:0] r;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pp     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    inj_en    = 1'b0;
    inj_val   = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Three beats summing to 21.
    beat(35'd5, 1'b0);
    beat(35'd7, 1'b0);
    check_eq("d034_pending", 64'(out_valid), 64'd0);
    beat(35'd9, 1'b1);
    check_eq("d034_valid", 64'(out_valid), 64'd1);
    check_eq("d034_sum", 64'(out_sum), 64'd21);
    check_eq("d034_trunc", 64'(out_trunc), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

    // Accumulator preloaded to all ones through the adder, then a carry out.
    cycle(1'b1, 35'd1, 1'b0, 1'b0, 1'b1, {1'b0, AllOnes});
    beat(35'd2, 1'b1);
`ifdef PSA_SATURATE_EN
    check_eq("d035_sum", 64'(out_sum), 64'({1'b1, AllOnes}));
`else
    check_eq("d035_sum", 64'(out_sum), 64'h4000000000001);
`endif
    check_eq("d035_ovf", 64'(out_ovf), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

    // Beat limit reached without last; a fifth beat is refused.
    for (int i = 0; i < 4; i++) beat(35'd1, 1'b0);
    check_eq("d036_sum", 64'(out_sum), 64'd4);
    check_eq("d036_trunc", 64'(out_trunc), 64'd1);
    beat(35'd1, 1'b0);
    check_eq("d036_refused", 64'(out_sum), 64'd4);

    // Hold with a beat pending, release, beat accepted only afterwards.
    for (int i = 0; i < 5; i++) beat(35'd8, 1'b1);
    check_eq("d037_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 35'd8, 1'b1, 1'b1, 1'b0, '0);
    check_eq("d037_released", 64'(out_valid), 64'd0);
    beat(35'd8, 1'b1);
    check_eq("d037_sum", 64'(out_sum), 64'd8);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

    // Reset mid-accumulation discards the partial sum.
    beat(35'd3, 1'b0);
    beat(35'd4, 1'b0);
    do_reset();
    check_eq("d038_acc", 64'(add_a), 64'd0);
    beat(35'd6, 1'b1);
    check_eq("d038_sum", 64'(out_sum), 64'd6);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

    // Single maximal beat.
    beat(35'h7FFFFFFFF, 1'b1);
    check_eq("d039_sum", 64'(out_sum), 64'h7FFFFFFFF);
    check_eq("d039_ovf", 64'(out_ovf), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

    // Randomized traffic with stalls, injected adder sums and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r = {$urandom(), $urandom()};
        cycle($urandom_range(0, 3) != 0,
              ($urandom_range(0, 1) == 0) ? 35'($urandom_range(0, 255)) : r[34:0],
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 7) == 0,
              {r[63:61], r[47:0]});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
